// File: rtl/sign_correct_serial_pkg.sv
// Shared definitions for the serial sign-correction stage: FSM states and byte width.
package sign_correct_serial_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sign_correct_serial_cla.sv
// 8-bit adder built from generate/propagate terms; used as the per-byte incrementer.
module CLA_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] gen;
    logic [7:0] prop;
    logic       c;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i] = prop[i] ^ c;
            c      = gen[i] | (prop[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/sign_correct_serial.sv
// Converts an unsigned magnitude plus sign into a two's-complement product,
// negating one byte per cycle through a single 8-bit adder with a held carry.
module sign_correct_serial
    import sign_correct_serial_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mag,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_prod
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t                state;
    state_t                next_state;
    logic [WIDTH-1:0]      mag;
    logic [WIDTH-1:0]      result;
    logic                  neg;
    logic                  carry;
    logic [IDX_W-1:0]      idx;
    logic                  last_byte;
    logic [BYTE_W-1:0]     cla_a;
    logic [BYTE_W-1:0]     cla_sum;
    logic                  cla_cout;

    assign last_byte = (idx == IDX_W'(NBYTES - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_prod  = result;

    // Negation is ~mag + 1: invert each byte and let the carry flop supply the +1.
    assign cla_a = neg ? ~mag[BYTE_W*idx +: BYTE_W] : mag[BYTE_W*idx +: BYTE_W];

    CLA_8bit u_cla (
        .a    (cla_a),
        .b    (8'h00),
        .cin  (carry),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (last_byte) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag    <= '0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag   <= in_mag;
                        neg   <= in_neg;
                        carry <= in_neg;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    // The carry out of the top byte is dropped, giving modulo 2^WIDTH.
                    result[BYTE_W*idx +: BYTE_W] <= cla_sum;
                    carry                        <= cla_cout;
                    if (!last_byte) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
